uart_rx_ctrl: RTL and testbench

//  Frame-sequencing FSM for the UART receiver. Tracks oversampling edges and bit position.

---
 rtl/uart_rx_ctrl.sv | 155 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: counts oversample edges and bit positions, drives the
// sampler/deserializer/checker enables and folds checker results into a frame-good strobe.
module uart_rx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] Prescale,
    input  logic       par_err,
    input  logic       strt_glitch,
    input  logic       stp_err,
    output logic [4:0] edge_count,
    output logic [3:0] bit_count,
    output logic       dat_samp_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       deser_en,
    output logic       data_valid,
    output logic       busy
);

    localparam logic [3:0] LastBit = 4'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] edge_count_q, edge_count_d;
    logic [3:0] bit_count_q, bit_count_d;
    logic [5:0] p_q;
    logic       start_frame;
    logic       bit_end;
    logic [4:0] edge_next;
    logic       data_valid_d;
    logic [5:0] half_pt;
    logic [5:0] deser_pt;

    logic dat_samp_en_q, strt_chk_en_q, par_chk_en_q, stp_chk_en_q;
    logic deser_en_q, data_valid_q, busy_q;

    assign bit_end   = ({1'b0, edge_count_q} == (p_q - 6'd1));
    assign edge_next = bit_end ? 5'd0 : edge_count_q + 5'd1;

    // Shift strobe lands two edges after the mid-bit sample; for the smallest prescales that
    // point falls past the bit, so it is pulled back to the last edge to keep one per bit.
    assign half_pt  = {1'b0, p_q[5:1]} + 6'd3;
    assign deser_pt = (half_pt > (p_q - 6'd1)) ? (p_q - 6'd1) : half_pt;

    always_comb begin
        state_d      = state_q;
        edge_count_d = 5'd0;
        bit_count_d  = 4'd0;
        start_frame  = 1'b0;
        data_valid_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (!RX_IN) begin
                    state_d     = StStart;
                    start_frame = 1'b1;
                end
            end
            StStart: begin
                edge_count_d = edge_next;
                if (bit_end) begin
                    state_d = strt_glitch ? StIdle : StData;
                end
            end
            StData: begin
                edge_count_d = edge_next;
                bit_count_d  = bit_count_q;
                if (bit_end) begin
                    if (bit_count_q == LastBit) begin
                        state_d     = PAR_EN ? StParity : StStop;
                        bit_count_d = 4'd0;
                    end else begin
                        bit_count_d = bit_count_q + 4'd1;
                    end
                end
            end
            StParity: begin
                edge_count_d = edge_next;
                if (bit_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                edge_count_d = edge_next;
                if (bit_end) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                data_valid_d = !stp_err && !(PAR_EN && par_err);
                if (!RX_IN) begin
                    state_d     = StStart;
                    start_frame = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are loaded from next-state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StIdle;
            edge_count_q  <= 5'd0;
            bit_count_q   <= 4'd0;
            p_q           <= 6'd0;
            dat_samp_en_q <= 1'b0;
            strt_chk_en_q <= 1'b0;
            par_chk_en_q  <= 1'b0;
            stp_chk_en_q  <= 1'b0;
            deser_en_q    <= 1'b0;
            data_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            edge_count_q  <= edge_count_d;
            bit_count_q   <= bit_count_d;
            if (start_frame) begin
                p_q <= Prescale;
            end
            dat_samp_en_q <= (state_d != StIdle);
            strt_chk_en_q <= (state_d == StStart);
            par_chk_en_q  <= (state_d == StParity);
            stp_chk_en_q  <= (state_d == StStop);
            deser_en_q    <= (state_d == StData) && ({1'b0, edge_count_d} == deser_pt);
            data_valid_q  <= data_valid_d;
            busy_q        <= (state_d != StIdle);
        end
    end

    assign edge_count  = edge_count_q;
    assign bit_count   = bit_count_q;
    assign dat_samp_en = dat_samp_en_q;
    assign strt_chk_en = strt_chk_en_q;
    assign par_chk_en  = par_chk_en_q;
    assign stp_chk_en  = stp_chk_en_q;
    assign deser_en    = deser_en_q;
    assign data_valid  = data_valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed frame table, hand-written corner sequences and random
// frames, all cross-checked every cycle against a frame-offset reference model.
module tb_uart_rx_ctrl;

    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] Prescale;
    logic       par_err;
    logic       strt_glitch;
    logic       stp_err;
    logic [4:0] edge_count;
    logic [3:0] bit_count;
    logic       dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en;
    logic       deser_en, data_valid, busy;

    uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .Prescale   (Prescale),
        .par_err    (par_err),
        .strt_glitch(strt_glitch),
        .stp_err    (stp_err),
        .edge_count (edge_count),
        .bit_count  (bit_count),
        .dat_samp_en(dat_samp_en),
        .strt_chk_en(strt_chk_en),
        .par_chk_en (par_chk_en),
        .stp_chk_en (stp_chk_en),
        .deser_en   (deser_en),
        .data_valid (data_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: m_t is the cycle offset since START was entered (-1 when idle);
    // every output is derived from that offset with plain arithmetic.
    int m_t   = -1;
    int m_p   = 8;
    bit m_par = 1'b0;
    bit m_dv  = 1'b0;

    function automatic int frame_len(input int p, input bit par);
        return (DW + 2 + (par ? 1 : 0)) * p;
    endfunction

    function automatic int deser_point(input int p);
        return (p / 2 + 3 > p - 1) ? p - 1 : p / 2 + 3;
    endfunction

    function automatic int next_t(input int t, input int p, input bit par, input bit rx,
                                  input bit glitch);
        if (t < 0) return rx ? -1 : 0;
        if (t == p - 1 && glitch) return -1;
        if (t == frame_len(p, par)) return rx ? -1 : 0;
        return t + 1;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_t  <= -1;
            m_dv <= 1'b0;
        end else begin
            m_t  <= next_t(m_t, m_p, PAR_EN, RX_IN, strt_glitch);
            m_dv <= (m_t == frame_len(m_p, PAR_EN)) && !stp_err && !(PAR_EN && par_err);
            if ((m_t < 0 || m_t == frame_len(m_p, PAR_EN)) && !RX_IN) m_p <= int'(Prescale);
        end
        m_par <= PAR_EN;
    end

    function automatic logic [15:0] exp_vec(input int t, input int p, input bit par,
                                            input bit dv);
        int l, region, e;
        logic [4:0] ec;
        logic [3:0] bc;
        logic bsy, st, dt, pc, sc, de;
        ec = 5'd0; bc = 4'd0; st = 1'b0; dt = 1'b0; pc = 1'b0; sc = 1'b0; de = 1'b0;
        bsy = (t >= 0);
        l = frame_len(p, par);
        if (t >= 0 && t < l) begin
            region = t / p;
            e      = t % p;
            ec     = 5'(e);
            st     = (region == 0);
            dt     = (region >= 1) && (region <= DW);
            bc     = dt ? 4'(region - 1) : 4'd0;
            pc     = par && (region == DW + 1);
            sc     = (region == DW + 1 + (par ? 1 : 0));
            de     = dt && (e == deser_point(p));
        end
        return {ec, bc, bsy, st, pc, sc, de, dv, bsy};
    endfunction

    function automatic logic [15:0] act_vec();
        return {edge_count, bit_count, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en,
                deser_en, data_valid, busy};
    endfunction

    int n_vec = 0;
    int n_err = 0;
    int deser_tot = 0, parchk_tot = 0, stpchk_tot = 0, dv_tot = 0, last_dv_cyc = 0;
    int c0 = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: compare all outputs at the falling edge, then return #1 after the next rise.
    task automatic tick();
        logic [15:0] a, e;
        @(negedge clk);
        a = act_vec();
        e = exp_vec(m_t, m_p, m_par, m_dv);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL cycle_outputs @%0d: got %h expected %h", cyc, a, e);
        end
        if (deser_en) deser_tot++;
        if (par_chk_en) parchk_tot++;
        if (stp_chk_en) stpchk_tot++;
        if (data_valid) begin
            dv_tot++;
            last_dv_cyc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) check("idle_timeout", 1, 0);
        repeat (2) tick();
    endtask

    task automatic drive_frame(input int p, input bit par, input logic [7:0] d,
                               input bit stp, input bit perr, input bit scramble);
        bit bits[12];
        int nb;
        nb = DW + 2 + (par ? 1 : 0);
        bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) bits[1 + i] = d[i];
        if (par) bits[DW + 1] = ^d;
        bits[nb - 1] = 1'b1;
        Prescale = 6'(p);
        PAR_EN   = par;
        stp_err  = stp;
        par_err  = perr;
        c0       = cyc;
        for (int b = 0; b < nb; b++) begin
            RX_IN = bits[b];
            repeat (p) tick();
            if (b == 0 && scramble) Prescale = 6'(2 * $urandom_range(2, 16));
        end
    endtask

    task automatic run_glitch(input int p);
        Prescale = 6'(p);
        RX_IN    = 1'b0;
        c0       = cyc;
        repeat (3) tick();
        RX_IN = 1'b1;
        repeat (p - 3) tick();
        strt_glitch = 1'b1;
        tick();
        strt_glitch = 1'b0;
    endtask

    typedef struct {
        int         p;
        bit         par;
        logic [7:0] data;
        bit         glitch;
        bit         stp;
        bit         perr;
        int         exp_deser;
        int         exp_parchk;
        int         exp_stpchk;
        int         exp_dv;
        int         exp_lat;
    } vec_t;

    localparam int NT = 9;
    vec_t tbl[NT];

    int s_deser, s_parchk, s_stpchk, s_dv;
    int r_kind, r_p;
    bit r_par, r_b2b, prev_frame, prev_par;

    initial begin
        tbl[0] = '{8,  1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8, 8,  8,  1, 90};
        tbl[1] = '{16, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8, 0,  16, 1, 162};
        tbl[2] = '{8,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 0,  0,  0, 0};
        tbl[3] = '{8,  1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 8, 0,  8,  0, 0};
        tbl[4] = '{8,  1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 8, 8,  8,  0, 0};
        tbl[5] = '{8,  1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 8, 0,  8,  1, 82};
        tbl[6] = '{4,  1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8, 4,  4,  1, 46};
        tbl[7] = '{32, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 8, 32, 32, 1, 354};
        tbl[8] = '{8,  1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 8, 8,  8,  0, 0};

        rst = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = 6'd8;
        par_err = 1'b0; strt_glitch = 1'b0; stp_err = 1'b0;
        repeat (3) tick();
        check("reset_outputs", int'(act_vec()), 0);
        rst = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < NT; i++) begin
            s_deser = deser_tot; s_parchk = parchk_tot; s_stpchk = stpchk_tot; s_dv = dv_tot;
            PAR_EN = tbl[i].par;
            if (tbl[i].glitch) run_glitch(tbl[i].p);
            else drive_frame(tbl[i].p, tbl[i].par, tbl[i].data, tbl[i].stp, tbl[i].perr, 1'b0);
            wait_idle();
            stp_err = 1'b0;
            par_err = 1'b0;
            check($sformatf("v%0d_deser", i), deser_tot - s_deser, tbl[i].exp_deser);
            check($sformatf("v%0d_parchk", i), parchk_tot - s_parchk, tbl[i].exp_parchk);
            check($sformatf("v%0d_stpchk", i), stpchk_tot - s_stpchk, tbl[i].exp_stpchk);
            check($sformatf("v%0d_dv", i), dv_tot - s_dv, tbl[i].exp_dv);
            if (tbl[i].exp_dv > 0) check($sformatf("v%0d_latency", i), last_dv_cyc - c0,
                                         tbl[i].exp_lat);
        end

        // Back-to-back: second start bit already low while the first frame sits in DONE.
        s_deser = deser_tot; s_dv = dv_tot;
        drive_frame(8, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        drive_frame(8, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        wait_idle();
        check("b2b_dv", dv_tot - s_dv, 2);
        check("b2b_deser", deser_tot - s_deser, 16);

        // Abort at data bit 4 with P=32, then a clean frame.
        s_deser = deser_tot; s_dv = dv_tot;
        Prescale = 6'd32; PAR_EN = 1'b1; RX_IN = 1'b0;
        repeat (5 * 32 + 4) tick();
        rst = 1'b0;
        tick();
        check("abort_outputs", int'(act_vec()), 0);
        RX_IN = 1'b1;
        rst = 1'b1;
        repeat (20) tick();
        wait_idle();
        check("abort_dv", dv_tot - s_dv, 0);
        check("abort_deser", deser_tot - s_deser, 4);
        s_dv = dv_tot;
        drive_frame(32, 1'b1, 8'h96, 1'b0, 1'b0, 1'b0);
        wait_idle();
        check("post_abort_dv", dv_tot - s_dv, 1);
        check("post_abort_latency", last_dv_cyc - c0, 354);

        prev_frame = 1'b0;
        prev_par   = 1'b0;
        for (int i = 0; i < 30; i++) begin
            r_kind = $urandom_range(0, 7);
            r_p    = 2 * $urandom_range(2, 16);
            r_par  = 1'($urandom_range(0, 1));
            r_b2b  = prev_frame && (r_kind != 0) && (r_par == prev_par) &&
                     ($urandom_range(0, 1) == 1);
            if (!r_b2b) repeat ($urandom_range(2, 6)) tick();
            if (r_kind == 0) begin
                run_glitch(r_p);
                prev_frame = 1'b0;
            end else begin
                drive_frame(r_p, r_par, 8'($urandom), $urandom_range(0, 4) == 0,
                            $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)));
                prev_frame = 1'b1;
                prev_par   = r_par;
            end
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
